// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and constants used by the instruction-register
// queue and its field decoder.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [3:0]  lc3b_opcode;
   typedef logic [2:0]  lc3b_reg;
   typedef logic [4:0]  lc3b_imm5;
   typedef logic [5:0]  lc3b_offset6;
   typedef logic [8:0]  lc3b_offset9;
   typedef logic [10:0] lc3b_offset11;

   localparam lc3b_opcode op_br   = 4'h0;
   localparam lc3b_opcode op_add  = 4'h1;
   localparam lc3b_opcode op_jsr  = 4'h4;
   localparam lc3b_opcode op_and  = 4'h5;
   localparam lc3b_opcode op_jmp  = 4'hC;
   localparam lc3b_opcode op_trap = 4'hF;

   localparam lc3b_reg R7 = 3'b111;

endpackage

// File: rtl/ir_decode.sv
// Splits the head instruction word into its LC-3b fields and produces the
// pre-sign-extended offsets consumed by the datapath.
module ir_decode
   import lc3b_types::*;
(
   input  lc3b_word     word_i,
   output lc3b_opcode   opcode_o,
   output lc3b_reg      dest_o,
   output lc3b_reg      src1_o,
   output lc3b_reg      src2_o,
   output logic         imm_o,
   output lc3b_imm5     imm5_o,
   output lc3b_offset6  offset6_o,
   output lc3b_offset9  offset9_o,
   output lc3b_offset11 offset11_o,
   output logic         jsrMode_o,
   output lc3b_word     sextImm5_o,
   output lc3b_word     sextOff6_o,
   output lc3b_word     sextOff9_o,
   output lc3b_word     sextOff11_o
);

   assign opcode_o   = word_i[15:12];
   assign src1_o     = word_i[8:6];
   assign src2_o     = word_i[2:0];
   assign imm_o      = word_i[5];
   assign imm5_o     = word_i[4:0];
   assign offset6_o  = word_i[5:0];
   assign offset9_o  = word_i[8:0];
   assign offset11_o = word_i[10:0];
   assign jsrMode_o  = word_i[11];

   // JSR/JSRR always link through R7, whatever bits 11:9 happen to hold.
   assign dest_o = (word_i[15:12] == op_jsr) ? R7 : word_i[11:9];

   assign sextImm5_o  = {{11{word_i[4]}},  word_i[4:0]};
   assign sextOff6_o  = {{10{word_i[5]}},  word_i[5:0]};
   assign sextOff9_o  = {{7{word_i[8]}},   word_i[8:0]};
   assign sextOff11_o = {{5{word_i[10]}},  word_i[10:0]};

endmodule

// File: rtl/lc3b_ir_queue.sv
// Instruction-register FIFO: lets fetch run ahead of execute, exposes the
// decoded head entry, and discards everything on a flush.
module lc3b_ir_queue
   import lc3b_types::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  lc3b_word         in_word,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count,
   output lc3b_opcode       opcode,
   output lc3b_reg          dest,
   output lc3b_reg          src1,
   output lc3b_reg          src2,
   output logic             imm,
   output lc3b_imm5         imm5,
   output lc3b_offset6      offset6,
   output lc3b_offset9      offset9,
   output lc3b_offset11     offset11,
   output logic             jsr_mode,
   output lc3b_word         sext_imm5,
   output lc3b_word         sext_off6,
   output lc3b_word         sext_off9,
   output lc3b_word         sext_off11
);

   localparam int PTR_W = $clog2(DEPTH);

   lc3b_word         mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             doEnq, doDeq;
   lc3b_word         headWord;

   // Handshakes come from the registered count only, never from the peer's inputs.
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign count     = count_q;
   assign doEnq     = in_valid && in_ready;
   assign doDeq     = out_valid && out_ready;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (doEnq) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (doDeq) rdPtr_d = rdPtr_q + PTR_W'(1);
         if (doEnq && !doDeq)      count_d = count_q + CNT_W'(1);
         else if (!doEnq && doDeq) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage is never cleared; an empty queue masks the head to zero instead.
   always_ff @(posedge clk) begin
      if (doEnq && !flush && !reset) mem_q[wrPtr_q] <= in_word;
   end

   assign headWord = out_valid ? mem_q[rdPtr_q] : '0;

   ir_decode u_decode (
      .word_i      (headWord),
      .opcode_o    (opcode),
      .dest_o      (dest),
      .src1_o      (src1),
      .src2_o      (src2),
      .imm_o       (imm),
      .imm5_o      (imm5),
      .offset6_o   (offset6),
      .offset9_o   (offset9),
      .offset11_o  (offset11),
      .jsrMode_o   (jsr_mode),
      .sextImm5_o  (sext_imm5),
      .sextOff6_o  (sext_off6),
      .sextOff9_o  (sext_off9),
      .sextOff11_o (sext_off11)
   );

endmodule

// File: tb/tb_lc3b_ir_queue.sv
// Scoreboard bench for lc3b_ir_queue: directed scenarios followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_lc3b_ir_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 0;
   logic             reset, flush, in_valid, out_ready;
   logic [15:0]      in_word;
   logic             in_ready, out_valid;
   logic [CNT_W-1:0] count;
   logic [3:0]       opcode;
   logic [2:0]       dest, src1, src2;
   logic             imm, jsr_mode;
   logic [4:0]       imm5;
   logic [5:0]       offset6;
   logic [8:0]       offset9;
   logic [10:0]      offset11;
   logic [15:0]      sext_imm5, sext_off6, sext_off9, sext_off11;

   int          vectors = 0;
   int          miscompares = 0;
   bit          monitorOn = 0;
   bit          consume = 0;
   logic [15:0] expQ [$];

   lc3b_ir_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .out_valid(out_valid), .out_ready(out_ready), .count(count),
      .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
      .imm(imm), .imm5(imm5), .offset6(offset6), .offset9(offset9),
      .offset11(offset11), .jsr_mode(jsr_mode),
      .sext_imm5(sext_imm5), .sext_off6(sext_off6),
      .sext_off9(sext_off9), .sext_off11(sext_off11)
   );

   always #5 clk = ~clk;

   function automatic int field(int w, int lsb, int bits);
      return (w >> lsb) % (1 << bits);
   endfunction

   // Two's-complement value of an n-bit field, folded back into 16 bits.
   function automatic int sextRef(int w, int lsb, int bits);
      int v;
      v = field(w, lsb, bits);
      if (v >= (1 << (bits - 1))) v = v - (1 << bits);
      return v & 16'hFFFF;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // One cycle of stimulus; the model is updated at the edge that applies it.
   task automatic applyStimulus(input bit v, input logic [15:0] w, input bit rdy,
                                input bit fl, input bit rst);
      bit accept;
      in_valid  = v;
      in_word   = w;
      out_ready = rdy;
      flush     = fl;
      reset     = rst;
      accept    = v && !fl && !rst && (expQ.size() < DEPTH);
      @(posedge clk);
      if (rst || fl) expQ.delete();
      else if (accept) expQ.push_back(w);
      #1;
   endtask

   always @(negedge clk) begin
      if (monitorOn) begin
         int hw;
         int op;
         hw = (expQ.size() != 0) ? int'(expQ[0]) : 0;
         op = field(hw, 12, 4);
         checkOutput("count",      int'(count),     expQ.size());
         checkOutput("out_valid",  int'(out_valid), int'(expQ.size() != 0));
         checkOutput("in_ready",   int'(in_ready),  int'(expQ.size() < DEPTH));
         checkOutput("opcode",     int'(opcode),    op);
         checkOutput("dest",       int'(dest),      (op == 4) ? 7 : field(hw, 9, 3));
         checkOutput("src1",       int'(src1),      field(hw, 6, 3));
         checkOutput("src2",       int'(src2),      field(hw, 0, 3));
         checkOutput("imm",        int'(imm),       field(hw, 5, 1));
         checkOutput("imm5",       int'(imm5),      field(hw, 0, 5));
         checkOutput("offset6",    int'(offset6),   field(hw, 0, 6));
         checkOutput("offset9",    int'(offset9),   field(hw, 0, 9));
         checkOutput("offset11",   int'(offset11),  field(hw, 0, 11));
         checkOutput("jsr_mode",   int'(jsr_mode),  field(hw, 11, 1));
         checkOutput("sext_imm5",  int'(sext_imm5), sextRef(hw, 0, 5));
         checkOutput("sext_off6",  int'(sext_off6), sextRef(hw, 0, 6));
         checkOutput("sext_off9",  int'(sext_off9), sextRef(hw, 0, 9));
         checkOutput("sext_off11", int'(sext_off11), sextRef(hw, 0, 11));
         consume = out_ready && !flush && !reset && (expQ.size() != 0);
      end
   end

   always @(posedge clk) begin
      if (consume) begin
         void'(expQ.pop_front());
         consume = 0;
      end
   end

   initial begin
      applyStimulus(0, 16'h0, 0, 0, 1);
      applyStimulus(0, 16'h0, 0, 0, 1);
      monitorOn = 1;
      applyStimulus(0, 16'h0, 0, 0, 0);

      // ADD R1,R2,R3 then a JSR with all-ones offset.
      applyStimulus(1, 16'h1283, 0, 0, 0);
      applyStimulus(0, 16'h0, 0, 0, 0);
      applyStimulus(1, 16'h4FFF, 1, 0, 0);
      applyStimulus(0, 16'h0, 0, 0, 0);
      applyStimulus(0, 16'h0, 1, 0, 0);
      applyStimulus(0, 16'h0, 0, 0, 0);

      // Fill to DEPTH, offer a fifth word, then drain through the wrap.
      for (int i = 1; i <= DEPTH; i++) applyStimulus(1, 16'h1000 + 16'(i), 0, 0, 0);
      applyStimulus(1, 16'h1005, 0, 0, 0);
      for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 16'h0, 1, 0, 0);

      // Steady stream at occupancy two.
      applyStimulus(1, 16'h2101, 0, 0, 0);
      applyStimulus(1, 16'h2102, 0, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 16'h3000 + 16'(i), 1, 0, 0);

      // Flush at count three with a word on offer.
      applyStimulus(1, 16'h6AAA, 0, 0, 0);
      applyStimulus(1, 16'h5555, 0, 1, 0);
      applyStimulus(0, 16'h0, 1, 0, 0);
      applyStimulus(1, 16'h7001, 0, 0, 0);
      applyStimulus(0, 16'h0, 1, 0, 0);

      // Same scenario with reset instead of flush.
      for (int i = 0; i < 3; i++) applyStimulus(1, 16'h8000 + 16'(i), 0, 0, 0);
      applyStimulus(1, 16'h5555, 0, 0, 1);
      applyStimulus(0, 16'h0, 1, 0, 0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(bit'($urandom_range(0, 3) != 0), 16'($urandom),
                       bit'($urandom_range(0, 2) == 0),
                       bit'($urandom_range(0, 24) == 0),
                       bit'($urandom_range(0, 60) == 0));
      end
      for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 16'h0, 1, 0, 0);

      monitorOn = 0;
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
